tx_bank_sched: RTL

Bank scheduler for the 2048x16 USB TX buffer, in the USB interface-clock domain between cmd_decode (writer) and usb_slavefifo (reader). It allocates free data banks to the writer, queues filled banks in order, and gives the handshake bank priority. It issues one read start per bank to the slave-FIFO controller, gated by the EP6 full flag. It also detects overflow and stalled transfers.

---
 rtl/tx_bank_sched.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/tx_bank_sched.sv
// rtl/tx_bank_sched.sv - TX buffer bank scheduler: data ring, handshake priority, overflow and timeout
module tx_bank_sched #(
  parameter int BADDR_NBIT = 4,
  parameter int TIMEOUT    = 65535
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_done,
  input  logic                  wr_hs,
  output logic [BADDR_NBIT-1:0] wr_baddr,
  output logic                  wr_ready,
  input  logic                  f_full,
  output logic                  tx_sop,
  output logic [BADDR_NBIT-1:0] tx_baddr,
  input  logic                  tx_done,
  output logic [BADDR_NBIT-1:0] level,
  output logic                  busy,
  output logic                  ovf,
  output logic                  err
);

  localparam int NB = 1 << BADDR_NBIT;
  localparam logic [BADDR_NBIT-1:0] LAST_BANK = BADDR_NBIT'(NB - 1);
  localparam logic [BADDR_NBIT-1:0] FIRST_BANK = BADDR_NBIT'(1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic {S_IDLE, S_XFER} state_t;

  state_t                  state_q, state_d;
  logic [BADDR_NBIT-1:0]   wp_q, wp_d;
  logic [BADDR_NBIT-1:0]   rp_q, rp_d;
  logic [BADDR_NBIT-1:0]   level_q, level_d;
  logic                    hs_pend_q, hs_pend_d;
  logic                    tx_sop_q, tx_sop_d;
  logic [BADDR_NBIT-1:0]   tx_baddr_q, tx_baddr_d;
  logic [TW-1:0]           tmo_q, tmo_d;
  logic                    ovf_q, ovf_d;
  logic                    err_q, err_d;

  logic wr_data;
  logic rd_data;
  logic wr_accept;

  // Data ring pointers step 1..NB-1 and skip bank 0, which belongs to the handshake.
  function automatic logic [BADDR_NBIT-1:0] bank_next(input logic [BADDR_NBIT-1:0] b);
    return (b == LAST_BANK) ? FIRST_BANK : b + FIRST_BANK;
  endfunction

  // Next-state logic for ring bookkeeping, handshake request and the issue/complete FSM.
  always_comb begin
    state_d    = state_q;
    wp_d       = wp_q;
    rp_d       = rp_q;
    level_d    = level_q;
    hs_pend_d  = hs_pend_q;
    tx_sop_d   = 1'b0;
    tx_baddr_d = tx_baddr_q;
    tmo_d      = tmo_q;
    ovf_d      = ovf_q;
    err_d      = err_q;

    wr_data = wr_done & ~wr_hs;
    rd_data = (state_q == S_XFER) & tx_done & (tx_baddr_q != '0);
    // A full ring still accepts a bank when one is being freed in the same cycle.
    wr_accept = wr_data & ((level_q != LAST_BANK) | rd_data);

    if (wr_data && !wr_accept) ovf_d = 1'b1;
    if (wr_accept) wp_d = bank_next(wp_q);
    if (rd_data) rp_d = bank_next(rp_q);

    unique case ({wr_accept, rd_data})
      2'b10:   level_d = level_q + FIRST_BANK;
      2'b01:   level_d = level_q - FIRST_BANK;
      default: level_d = level_q;
    endcase

    unique case (state_q)
      S_IDLE: begin
        if (hs_pend_q) begin
          // Handshake goes out even while EP6 is full.
          tx_sop_d   = 1'b1;
          tx_baddr_d = '0;
          hs_pend_d  = 1'b0;
          tmo_d      = '0;
          state_d    = S_XFER;
        end else if ((level_q != '0) && !f_full) begin
          tx_sop_d   = 1'b1;
          tx_baddr_d = rp_q;
          tmo_d      = '0;
          state_d    = S_XFER;
        end
      end
      S_XFER: begin
        if (tx_done) begin
          state_d = S_IDLE;
        end else if (tmo_q == TMO_LAST) begin
          // Abort leaves rp/level alone so the same bank is retried.
          err_d   = 1'b1;
          state_d = S_IDLE;
          if (tx_baddr_q == '0) hs_pend_d = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A new handshake request merges with any pending one.
    if (wr_done && wr_hs) hs_pend_d = 1'b1;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wp_q       <= FIRST_BANK;
      rp_q       <= FIRST_BANK;
      level_q    <= '0;
      hs_pend_q  <= 1'b0;
      tx_sop_q   <= 1'b0;
      tx_baddr_q <= '0;
      tmo_q      <= '0;
      ovf_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      level_q    <= level_d;
      hs_pend_q  <= hs_pend_d;
      tx_sop_q   <= tx_sop_d;
      tx_baddr_q <= tx_baddr_d;
      tmo_q      <= tmo_d;
      ovf_q      <= ovf_d;
      err_q      <= err_d;
    end
  end

  assign wr_baddr = wp_q;
  assign wr_ready = (level_q != LAST_BANK);
  assign tx_sop   = tx_sop_q;
  assign tx_baddr = tx_baddr_q;
  assign level    = level_q;
  assign busy     = (state_q == S_XFER);
  assign ovf      = ovf_q;
  assign err      = err_q;

endmodule
